// File: rtl/line_fetch_scheduler.sv
// Per-scanline fetch scheduler: kicks a render pass at hblank and shares one ROM read port
// round-robin among the layer fetchers. Optional build macro: SCHED_FIXED_PRIO_EN.
module line_fetch_scheduler #(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned AW           = 24,
    parameter int unsigned DW           = 32,
    parameter int unsigned LINE_START_H = 256,
    parameter int unsigned VIS_FIRST    = 16,
    parameter int unsigned VIS_LAST     = 239
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clk_pix_i,
    input  logic [8:0]         hc_i,
    input  logic [8:0]         vc_i,
    output logic               line_start_o,
    output logic [8:0]         render_ln_o,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ-1:0]    done_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rd_valid_o,
    output logic [DW-1:0]      rd_data_o,
    output logic               rom_req_o,
    output logic [AW-1:0]      rom_addr_o,
    input  logic               rom_ack_i,
    input  logic [DW-1:0]      rom_data_i,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StArb, StXfer, StAbort} state_e;

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gnt_idx_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rd_valid_q;
    logic [DW-1:0]   rd_data_q;
    logic            rom_req_q;
    logic [AW-1:0]   rom_addr_q;
    logic            line_start_q;
    logic [8:0]      render_ln_q;
    logic [8:0]      kick_vc_q;
    logic            overrun_q;

    logic            kick;
    logic            xfer_end;
    logic            settle;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] pick_oh;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [AW-1:0]   pick_addr;
    logic [IW-1:0]   ptr_next;
    int unsigned     scan;

    assign kick = clk_pix_i && (hc_i == 9'(LINE_START_H)) &&
                  (vc_i >= 9'(VIS_FIRST)) && (vc_i <= 9'(VIS_LAST));

    assign xfer_end = rom_ack_i && ((state_q == StXfer) || (state_q == StAbort));

    // Requesters need one clk to react to line_start or to their own rd_valid.
    assign settle = line_start_q || (rd_valid_q != '0);

    always_comb begin
        pending    = req_i & ~done_i;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        pick_addr  = '0;
        scan       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = 32'(ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!pick_valid && pending[IW'(scan)]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(scan);
            end
        end
`ifdef SCHED_FIXED_PRIO_EN
        if (pending[0]) begin
            pick_valid = 1'b1;
            pick_idx   = '0;
        end
`endif
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_idx == IW'(k)) begin
                pick_oh[k] = pick_valid;
                pick_addr  = req_addr_i[k*AW +: AW];
            end
        end
    end

    always_comb begin
        if (gnt_idx_q == IW'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx_q + 1'b1;
        end
`ifdef SCHED_FIXED_PRIO_EN
        if (gnt_idx_q == '0) begin
            ptr_next = ptr_q;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            gnt_idx_q    <= '0;
            gnt_q        <= '0;
            rd_valid_q   <= '0;
            rd_data_q    <= '0;
            rom_req_q    <= 1'b0;
            rom_addr_q   <= '0;
            line_start_q <= 1'b0;
            render_ln_q  <= '0;
            kick_vc_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            line_start_q <= 1'b0;
            rd_valid_q   <= '0;

            // The ROM transaction completes the same way whether or not it was aborted.
            if (xfer_end) begin
                gnt_q      <= '0;
                rom_req_q  <= 1'b0;
                rd_data_q  <= rom_data_i;
                rd_valid_q <= gnt_q;
                ptr_q      <= ptr_next;
            end

            unique case (state_q)
                StIdle: begin
                    if (kick) begin
                        line_start_q <= 1'b1;
                        render_ln_q  <= vc_i + 9'd1;
                        state_q      <= StArb;
                    end
                end
                StArb: begin
                    if (kick) begin
                        overrun_q    <= 1'b1;
                        line_start_q <= 1'b1;
                        render_ln_q  <= vc_i + 9'd1;
                    end else if (settle) begin
                        state_q <= StArb;
                    end else if (&done_i) begin
                        state_q <= StIdle;
                    end else if (pick_valid) begin
                        gnt_q      <= pick_oh;
                        gnt_idx_q  <= pick_idx;
                        rom_req_q  <= 1'b1;
                        rom_addr_q <= pick_addr;
                        state_q    <= StXfer;
                    end
                end
                StXfer: begin
                    if (rom_ack_i) begin
                        state_q <= StArb;
                        if (kick) begin
                            overrun_q    <= 1'b1;
                            line_start_q <= 1'b1;
                            render_ln_q  <= vc_i + 9'd1;
                        end
                    end else if (kick) begin
                        overrun_q <= 1'b1;
                        kick_vc_q <= vc_i;
                        state_q   <= StAbort;
                    end
                end
                StAbort: begin
                    if (rom_ack_i) begin
                        line_start_q <= 1'b1;
                        render_ln_q  <= (kick ? vc_i : kick_vc_q) + 9'd1;
                        state_q      <= StArb;
                    end else if (kick) begin
                        kick_vc_q <= vc_i;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign line_start_o = line_start_q;
    assign render_ln_o  = render_ln_q;
    assign gnt_o        = gnt_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign rom_req_o    = rom_req_q;
    assign rom_addr_o   = rom_addr_q;
    assign busy_o       = (state_q != StIdle);
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Scoreboard bench for line_fetch_scheduler: expected grant order is queued at stimulus time
// and checked against each rd_valid pulse; a small ROM and requester model close the loop.
module tb_line_fetch_scheduler;

    localparam int NREQ = 3;
    localparam int AW   = 24;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clk_pix = 1'b0;
    logic [8:0]        hc = '0;
    logic [8:0]        vc = '0;
    logic              line_start;
    logic [8:0]        render_ln;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rd_valid;
    logic [DW-1:0]     rd_data;
    logic              rom_req;
    logic [AW-1:0]     rom_addr;
    logic              rom_ack = 1'b0;
    logic [DW-1:0]     rom_data = '0;
    logic              busy;
    logic              overrun;

    int want[NREQ]   = '{default: 0};
    int served[NREQ] = '{default: 0};
    int exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int ls_cnt = 0;
    int rv_cnt = 0;
    int rq_cycles = 0;
    logic [8:0] ls_ln = '0;
    int rom_delay = 2;
    bit rom_hold = 1'b0;
    int wait_cnt = 0;
    int mon_e;

    always #5 clk = ~clk;

    line_fetch_scheduler dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clk_pix_i   (clk_pix),
        .hc_i        (hc),
        .vc_i        (vc),
        .line_start_o(line_start),
        .render_ln_o (render_ln),
        .req_i       (req),
        .req_addr_i  (req_addr),
        .done_i      (done),
        .gnt_o       (gnt),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .rom_req_o   (rom_req),
        .rom_addr_o  (rom_addr),
        .rom_ack_i   (rom_ack),
        .rom_data_i  (rom_data),
        .busy_o      (busy),
        .overrun_o   (overrun)
    );

    function automatic logic [AW-1:0] addr_of(input int i);
        return 24'(i + 1) * 24'h011111;
    endfunction

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
        return {~a[7:0], a};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester model: wants outstanding -> req high, nothing left -> done high.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i]  = served[i] < want[i];
            done[i] = served[i] >= want[i];
            req_addr[i*AW +: AW] = addr_of(i);
        end
    end

    // Monitor/scoreboard first, then the ROM model drives its next ack.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid != '0 || rom_ack) begin
                check_eq("ack_to_rdvalid", 64'(rd_valid != '0), 64'(rom_ack));
            end
            if (rd_valid != '0) begin
                rv_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("rd_valid_unexpected", 64'(rd_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("rd_valid_idx", 64'(rd_valid), 64'(1) << mon_e);
                    check_eq("rd_data", 64'(rd_data), 64'(mk_data(addr_of(mon_e))));
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (rd_valid[i]) served[i]++;
                end
            end
            if (line_start) begin
                ls_cnt++;
                ls_ln = render_ln;
            end
            if (rom_req) rq_cycles++;
        end
        rom_ack = 1'b0;
        if (rom_req && !rom_hold && !rst) begin
            if (wait_cnt >= rom_delay) begin
                rom_ack  = 1'b1;
                rom_data = mk_data(rom_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic kick(input logic [8:0] v, input logic pix);
        @(negedge clk);
        clk_pix = pix;
        hc      = 9'd256;
        vc      = v;
        @(negedge clk);
        clk_pix = 1'b1;
        hc      = 9'd0;
    endtask

    task automatic wait_rom_req(input string tag);
        int n = 0;
        while (!rom_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(rom_req), 64'(1));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(exp_q.size() == 0 && !busy), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rv0;
        int rq0;
        int n;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", 64'({line_start, render_ln, gnt, rd_valid, rom_req, busy, overrun}),
                 64'(0));
        check_eq("reset_data_addr", 64'({rd_data, rom_addr}), 64'(0));
        rst     = 1'b0;
        clk_pix = 1'b1;

        // Reset while a ROM transaction is outstanding.
        rom_hold = 1'b1;
        want[0]  = 1;
        kick(9'd20, 1'b1);
        wait_rom_req("t1_rom_req");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_eq("t1_rst_mid_xfer", 64'({line_start, gnt, rd_valid, rom_req, busy, overrun}), 64'(0));
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        rom_hold = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t1_no_rdvalid", 64'(rv_cnt), 64'(0));
        check_eq("t1_idle", 64'({busy, rom_req}), 64'(0));

        // Full pass with all three requesters.
        base = ls_cnt;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        want[1]++;
        want[2]++;
        kick(9'd100, 1'b1);
        @(negedge clk);
        check_eq("t2_line_start", 64'(ls_cnt - base), 64'(1));
        check_eq("t2_render_ln", 64'(ls_ln), 64'(101));
        check_eq("t2_busy", 64'(busy), 64'(1));
        wait_drain("t2_drain");
        check_eq("t2_overrun", 64'(overrun), 64'(0));

        // Requester 0 raises its request mid-pass.
`ifdef SCHED_FIXED_PRIO_EN
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(2);
`else
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(0);
`endif
        want[1]++;
        want[2]++;
        kick(9'd101, 1'b1);
        n = 0;
        while (!gnt[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_gnt1", 64'(gnt), 64'(3'b010));
        want[0]++;
        wait_drain("t3_drain");
        check_eq("t3_render_ln", 64'(ls_ln), 64'(102));

        // Everyone already done: pass ends without touching the ROM.
        base = ls_cnt;
        rq0  = rq_cycles;
        kick(9'd102, 1'b1);
        @(negedge clk);
        check_eq("t4_busy_in_arb", 64'(busy), 64'(1));
        repeat (3) @(negedge clk);
        check_eq("t4_idle", 64'(busy), 64'(0));
        check_eq("t4_no_rom_req", 64'(rq_cycles - rq0), 64'(0));
        check_eq("t4_line_start", 64'(ls_cnt - base), 64'(1));
        check_eq("t4_overrun", 64'(overrun), 64'(0));

        // Kick during a held transfer, then a second kick absorbed in abort.
        rom_hold = 1'b1;
        exp_q.push_back(0);
        want[0]++;
        kick(9'd50, 1'b1);
        wait_rom_req("t5_rom_req");
        base = ls_cnt;
        rv0  = rv_cnt;
        kick(9'd60, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("t5_overrun", 64'(overrun), 64'(1));
        check_eq("t5_held", 64'({busy, rom_req}), 64'(2'b11));
        check_eq("t5_no_line_start", 64'(ls_cnt - base), 64'(0));
        kick(9'd70, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("t5_no_rdvalid_yet", 64'(rv_cnt - rv0), 64'(0));
        rom_hold = 1'b0;
        wait_drain("t5_drain");
        check_eq("t5_line_start_after_ack", 64'(ls_cnt - base), 64'(1));
        check_eq("t5_render_ln", 64'(ls_ln), 64'(71));
        check_eq("t5_overrun_sticky", 64'(overrun), 64'(1));

        // Continuous requests with ack on the first rom_req cycle.
        rom_delay = 0;
        rq0       = rq_cycles;
`ifdef SCHED_FIXED_PRIO_EN
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(2);
`else
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(0);
`endif
        for (int i = 0; i < NREQ; i++) want[i] += 2;
        kick(9'd200, 1'b1);
        wait_drain("t6_drain");
        check_eq("t6_rom_req_cycles", 64'(rq_cycles - rq0), 64'(6));

        // Kick window boundaries and pixel-enable gating.
        base = ls_cnt;
        kick(9'd240, 1'b1);
        kick(9'd15, 1'b1);
        kick(9'd100, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("t7_no_line_start", 64'(ls_cnt - base), 64'(0));
        check_eq("t7_idle", 64'(busy), 64'(0));
        kick(9'd239, 1'b1);
        @(negedge clk);
        check_eq("t7_last_line_start", 64'(ls_cnt - base), 64'(1));
        check_eq("t7_last_render_ln", 64'(ls_ln), 64'(240));
        wait_drain("t7_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
